// File: rtl/gate_response_checker.sv
// Gate response checker: compares observed outputs of a 2-input gate against an
// expected truth table, tracks input coverage, counts mismatches and flags a timeout.
module gate_response_checker #(
    parameter logic [3:0]  EXPECT  = 4'b0111,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_sample_valid,
    output logic             o_sample_ready,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_err_count,
    output logic [3:0]       o_covered,
    output logic [1:0]       o_first_fail_idx,
    output logic             o_first_fail_valid
);

    // The counter only has to hold 0..TIMEOUT-1; it never advances past that.
    localparam int unsigned CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           r_state;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic [CNT_W-1:0] r_err;
    logic [3:0]       r_covered;
    logic [1:0]       r_ff_idx;
    logic             r_ff_valid;
    logic [CYC_W-1:0] r_cycle;

    logic             w_accept;
    logic [1:0]       w_idx;
    logic             w_mismatch;
    logic [3:0]       w_covered_nxt;
    logic [CNT_W-1:0] w_err_nxt;
    logic             w_complete;
    logic             w_expired;

    // Sample decode: accept, mismatch, and the coverage/error values after this sample.
    always_comb begin
        w_accept      = i_sample_valid & r_ready;
        w_idx         = {i_a, i_b};
        w_mismatch    = w_accept & (i_y != EXPECT[w_idx]);
        w_covered_nxt = r_covered;
        if (w_accept) begin
            w_covered_nxt[w_idx] = 1'b1;
        end
        w_err_nxt = r_err;
        if (w_mismatch && (r_err != ERR_MAX)) begin
            w_err_nxt = r_err + 1'b1;
        end
        w_complete = w_accept & (w_covered_nxt == 4'b1111);
        w_expired  = (r_cycle == CYC_LAST);
    end

    // Session FSM with all outputs registered; ready/busy mirror the RUN state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err      <= '0;
            r_covered  <= 4'b0000;
            r_ff_idx   <= 2'b00;
            r_ff_valid <= 1'b0;
            r_cycle    <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state    <= StRun;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_err      <= '0;
                        r_covered  <= 4'b0000;
                        r_ff_idx   <= 2'b00;
                        r_ff_valid <= 1'b0;
                        r_cycle    <= '0;
                    end
                end
                StRun: begin
                    r_covered <= w_covered_nxt;
                    r_err     <= w_err_nxt;
                    r_cycle   <= r_cycle + 1'b1;
                    if (w_mismatch && !r_ff_valid) begin
                        r_ff_idx   <= w_idx;
                        r_ff_valid <= 1'b1;
                    end
                    // Completion wins over a timeout landing on the same edge.
                    if (w_complete) begin
                        r_state   <= StDone;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b0;
                        r_pass    <= (w_err_nxt == '0);
                    end else if (w_expired) begin
                        r_state   <= StDone;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sample_ready     = r_ready;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_pass             = r_pass;
    assign o_timeout          = r_timeout;
    assign o_err_count        = r_err;
    assign o_covered          = r_covered;
    assign o_first_fail_idx   = r_ff_idx;
    assign o_first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: default, short-timeout and narrow-counter instances.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst_n, start, sv, ia, ib, iy;

    int n_chk = 0;
    int n_err = 0;

    // Default instance
    logic       d_rdy, d_busy, d_done, d_pass, d_to, d_ffv;
    logic [7:0] d_err;
    logic [3:0] d_cov;
    logic [1:0] d_ffi;
    // TIMEOUT=8 instance
    logic       t_rdy, t_busy, t_done, t_pass, t_to, t_ffv;
    logic [7:0] t_err;
    logic [3:0] t_cov;
    logic [1:0] t_ffi;
    // CNT_W=2 instance
    logic       s_rdy, s_busy, s_done, s_pass, s_to, s_ffv;
    logic [1:0] s_err;
    logic [3:0] s_cov;
    logic [1:0] s_ffi;

    gate_response_checker u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sample_valid(sv),
        .o_sample_ready(d_rdy), .i_a(ia), .i_b(ib), .i_y(iy),
        .o_busy(d_busy), .o_done(d_done), .o_pass(d_pass), .o_timeout(d_to),
        .o_err_count(d_err), .o_covered(d_cov), .o_first_fail_idx(d_ffi),
        .o_first_fail_valid(d_ffv)
    );

    gate_response_checker #(.TIMEOUT(8)) u_to (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sample_valid(sv),
        .o_sample_ready(t_rdy), .i_a(ia), .i_b(ib), .i_y(iy),
        .o_busy(t_busy), .o_done(t_done), .o_pass(t_pass), .o_timeout(t_to),
        .o_err_count(t_err), .o_covered(t_cov), .o_first_fail_idx(t_ffi),
        .o_first_fail_valid(t_ffv)
    );

    gate_response_checker #(.CNT_W(2), .TIMEOUT(64)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sample_valid(sv),
        .o_sample_ready(s_rdy), .i_a(ia), .i_b(ib), .i_y(iy),
        .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_timeout(s_to),
        .o_err_count(s_err), .o_covered(s_cov), .o_first_fail_idx(s_ffi),
        .o_first_fail_valid(s_ffv)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic a, input logic b, input logic y);
        sv = 1'b1;
        ia = a;
        ib = b;
        iy = y;
        tick();
        sv = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; sv = 1'b1; ia = 1'b1; ib = 1'b1; iy = 1'b0;
        tick();
        tick();
        // Reset values; start and sample during reset are ignored
        chk("rst_ready", {31'd0, d_rdy}, 0);
        chk("rst_busy", {31'd0, d_busy}, 0);
        chk("rst_done", {31'd0, d_done}, 0);
        chk("rst_pass", {31'd0, d_pass}, 0);
        chk("rst_timeout", {31'd0, d_to}, 0);
        chk("rst_ffv", {31'd0, d_ffv}, 0);
        chk("rst_err", {24'd0, d_err}, 0);
        chk("rst_cov", {28'd0, d_cov}, 0);
        chk("rst_ffi", {30'd0, d_ffi}, 0);
        chk("rst_sat_err", {30'd0, s_err}, 0);
        chk("rst_to_busy", {31'd0, t_busy}, 0);

        // Valid held high in IDLE: no accept
        rst_n = 1'b1; start = 1'b0;
        tick();
        tick();
        chk("idle_ready", {31'd0, d_rdy}, 0);
        chk("idle_cov", {28'd0, d_cov}, 0);

        // Clean NAND sweep
        do_start();
        chk("run_busy", {31'd0, d_busy}, 1);
        chk("run_ready", {31'd0, d_rdy}, 1);
        chk("run_cov0", {28'd0, d_cov}, 0);
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        chk("clean_not_done", {31'd0, d_done}, 0);
        send(1'b1, 1'b1, 1'b0);
        chk("clean_done", {31'd0, d_done}, 1);
        chk("clean_busy", {31'd0, d_busy}, 0);
        chk("clean_ready", {31'd0, d_rdy}, 0);
        chk("clean_pass", {31'd0, d_pass}, 1);
        chk("clean_err", {24'd0, d_err}, 0);
        chk("clean_cov", {28'd0, d_cov}, 4'hF);
        chk("clean_ffv", {31'd0, d_ffv}, 0);
        chk("clean_timeout", {31'd0, d_to}, 0);
        // Results hold in DONE; samples ignored
        send(1'b1, 1'b1, 1'b1);
        chk("hold_err", {24'd0, d_err}, 0);
        chk("hold_pass", {31'd0, d_pass}, 1);

        // Faulty gate: 10/0 and 11/1 mismatch
        do_start();
        chk("restart_done", {31'd0, d_done}, 0);
        chk("restart_cov", {28'd0, d_cov}, 0);
        chk("restart_pass", {31'd0, d_pass}, 0);
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        chk("fault_err1", {24'd0, d_err}, 1);
        send(1'b1, 1'b1, 1'b1);
        chk("fault_done", {31'd0, d_done}, 1);
        chk("fault_pass", {31'd0, d_pass}, 0);
        chk("fault_err", {24'd0, d_err}, 2);
        chk("fault_ffi", {30'd0, d_ffi}, 2);
        chk("fault_ffv", {31'd0, d_ffv}, 1);

        // Duplicates, and start during RUN ignored
        do_start();
        send(1'b1, 1'b1, 1'b0);
        start = 1'b1;
        send(1'b1, 1'b1, 1'b0);
        start = 1'b0;
        send(1'b1, 1'b1, 1'b0);
        chk("dup_cov", {28'd0, d_cov}, 4'h8);
        chk("dup_busy", {31'd0, d_busy}, 1);
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        chk("dup_not_done", {31'd0, d_done}, 0);
        send(1'b1, 1'b0, 1'b1);
        chk("dup_done", {31'd0, d_done}, 1);
        chk("dup_pass", {31'd0, d_pass}, 1);
        chk("dup_err", {24'd0, d_err}, 0);

        // Reset mid-session; sample in the reset cycle is dropped
        do_start();
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 0);
        rst_n = 1'b0; sv = 1'b1; ia = 1'b1; ib = 1'b0; iy = 1'b1;
        tick();
        rst_n = 1'b1; sv = 1'b0;
        chk("mid_rst_busy", {31'd0, d_busy}, 0);
        chk("mid_rst_ready", {31'd0, d_rdy}, 0);
        chk("mid_rst_done", {31'd0, d_done}, 0);
        chk("mid_rst_cov", {28'd0, d_cov}, 0);
        chk("mid_rst_err", {24'd0, d_err}, 0);
        chk("mid_rst_ffv", {31'd0, d_ffv}, 0);
        tick();
        chk("post_rst_done", {31'd0, d_done}, 0);
        do_start();
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        chk("resweep_done", {31'd0, d_done}, 1);
        chk("resweep_pass", {31'd0, d_pass}, 1);

        // Timeout with TIMEOUT=8: only 00 and 01 fed
        do_reset();
        do_start();
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        repeat (5) tick();
        chk("to_pre_done", {31'd0, t_done}, 0);
        chk("to_pre_busy", {31'd0, t_busy}, 1);
        tick();
        chk("to_done", {31'd0, t_done}, 1);
        chk("to_timeout", {31'd0, t_to}, 1);
        chk("to_pass", {31'd0, t_pass}, 0);
        chk("to_cov", {28'd0, t_cov}, 4'h3);
        chk("to_busy", {31'd0, t_busy}, 0);

        // Completion on the timeout edge wins
        do_start();
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        repeat (4) tick();
        chk("prio_pre_busy", {31'd0, t_busy}, 1);
        send(1'b1, 1'b1, 1'b0);
        chk("prio_done", {31'd0, t_done}, 1);
        chk("prio_timeout", {31'd0, t_to}, 0);
        chk("prio_pass", {31'd0, t_pass}, 1);
        chk("prio_cov", {28'd0, t_cov}, 4'hF);

        // Saturation with CNT_W=2
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b1);
        chk("sat_err3", {30'd0, s_err}, 3);
        chk("sat_ffi", {30'd0, s_ffi}, 3);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b1);
        chk("sat_err_hold", {30'd0, s_err}, 3);
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        chk("sat_done", {31'd0, s_done}, 1);
        chk("sat_err", {30'd0, s_err}, 3);
        chk("sat_pass", {31'd0, s_pass}, 0);
        chk("sat_timeout", {31'd0, s_to}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
